// File: rtl/ppfifo_src_pkg.sv
// Shared encodings for the ping-pong FIFO stimulus source.
package ppfifo_src_pkg;

    typedef enum logic [1:0] {
        MODE_INDEX = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/ppfifo_src_pattern.sv
// Data pattern generators: running counter, Galois LFSR and walking-one.
// Only the generator selected by i_mode advances on a strobe.
module ppfifo_src_pattern
    import ppfifo_src_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic                  i_adv,
    input  logic [1:0]            i_mode,
    input  logic [15:0]           i_index,
    output logic [DATA_WIDTH-1:0] o_value
);

    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0] walk_q, walk_d;

    always_comb begin
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        walk_d  = walk_q;
        o_value = '0;
        unique case (mode_e'(i_mode))
            MODE_INDEX: o_value = DATA_WIDTH'(i_index);
            MODE_COUNT: begin
                o_value = cnt_q;
                if (i_adv) cnt_d = cnt_q + DATA_WIDTH'(1);
            end
            MODE_LFSR: begin
                o_value = lfsr_q;
                if (i_adv) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
            end
            MODE_WALK: begin
                o_value = walk_q;
                if (i_adv) walk_d = {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]};
            end
            default: o_value = '0;
        endcase
    end

    // An all-zero LFSR would lock up, so a zero seed starts it at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= i_seed;
            lfsr_q <= (i_seed == '0) ? DATA_WIDTH'(1) : i_seed;
            walk_q <= DATA_WIDTH'(1);
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            walk_q <= walk_d;
        end
    end

endmodule

// File: rtl/ppfifo_src_gen.sv
// Multi-channel ping-pong FIFO write source: round-robin grant, patterned
// data, programmable gap, optional frame cap and frame statistics.
module ppfifo_src_gen
    import ppfifo_src_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_CH     = 2,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_seed,
    input  logic [7:0]            i_gap,
    input  logic [15:0]           i_max_len,
    input  logic [NUM_CH-1:0]     i_wr_rdy,
    output logic [NUM_CH-1:0]     o_wr_act,
    input  logic [15:0]           i_wr_size,
    output logic                  o_wr_stb,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_frame_done,
    output logic [15:0]           o_frame_count
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            gap_q, gap_d;
    logic [NUM_CH-1:0]     act_q, act_d;
    logic                  stb_q, stb_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           fcount_q, fcount_d;

    logic                  grant_vld;
    logic [PTR_W-1:0]      grant_ch;
    logic [15:0]           len;
    logic                  adv;
    logic [DATA_WIDTH-1:0] pat_value;

    assign len = (i_max_len != 16'd0 && i_max_len < i_wr_size) ? i_max_len : i_wr_size;

    // Round-robin: search channels at/above the pointer first, then wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!grant_vld && i_wr_rdy[j] && (PTR_W'(j) >= rr_q)) begin
                grant_vld = 1'b1;
                grant_ch  = PTR_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!grant_vld && i_wr_rdy[j]) begin
                grant_vld = 1'b1;
                grant_ch  = PTR_W'(j);
            end
        end
    end

    ppfifo_src_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_pattern (
        .clk     (clk),
        .rst     (rst),
        .i_seed  (i_seed),
        .i_adv   (adv),
        .i_mode  (i_mode),
        .i_index (count_q),
        .o_value (pat_value)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            count_q  <= '0;
            gap_q    <= '0;
            act_q    <= '0;
            stb_q    <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            count_q  <= count_d;
            gap_q    <= gap_d;
            act_q    <= act_d;
            stb_q    <= stb_d;
            done_q   <= done_d;
            data_q   <= data_d;
            fcount_q <= fcount_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (i_enable && grant_vld) state_d = S_FILL;
            S_FILL:    if (i_enable && count_q == len) state_d = S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rr_d     = rr_q;
        count_d  = count_q;
        gap_d    = gap_q;
        act_d    = act_q;
        stb_d    = 1'b0;
        done_d   = 1'b0;
        data_d   = data_q;
        fcount_d = fcount_q;
        adv      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_enable && grant_vld) begin
                    act_d   = NUM_CH'(1) << grant_ch;
                    count_d = '0;
                    gap_d   = '0;
                    rr_d    = (grant_ch == PTR_W'(NUM_CH - 1)) ? '0 : grant_ch + PTR_W'(1);
                end
            end
            S_FILL: begin
                // The length check precedes the gap wait, so the release
                // follows the last strobe immediately.
                if (i_enable) begin
                    if (count_q == len) begin
                        act_d    = '0;
                        done_d   = 1'b1;
                        fcount_d = fcount_q + 16'd1;
                    end else if (gap_q != 8'd0) begin
                        gap_d = gap_q - 8'd1;
                    end else begin
                        stb_d   = 1'b1;
                        data_d  = pat_value;
                        count_d = count_q + 16'd1;
                        gap_d   = i_gap;
                        adv     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_wr_act      = act_q;
    assign o_wr_stb      = stb_q;
    assign o_wr_data     = data_q;
    assign o_frame_done  = done_q;
    assign o_frame_count = fcount_q;

endmodule

// File: tb/tb_ppfifo_src_gen.sv
// Scoreboard bench for ppfifo_src_gen: frames are planned from a pattern
// model and checked by an independent monitor as the DUT emits them.
module tb_ppfifo_src_gen;

    localparam int         DW   = 8;
    localparam int         NCH  = 2;
    localparam logic [7:0] TAPS = 8'hB8;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_enable;
    logic [1:0]     i_mode;
    logic [DW-1:0]  i_seed;
    logic [7:0]     i_gap;
    logic [15:0]    i_max_len;
    logic [NCH-1:0] i_wr_rdy;
    logic [NCH-1:0] o_wr_act;
    logic [15:0]    i_wr_size;
    logic           o_wr_stb;
    logic [DW-1:0]  o_wr_data;
    logic           o_frame_done;
    logic [15:0]    o_frame_count;

    always #5 clk = ~clk;

    ppfifo_src_gen #(.DATA_WIDTH(DW), .NUM_CH(NCH), .LFSR_TAPS(TAPS)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_seed        (i_seed),
        .i_gap         (i_gap),
        .i_max_len     (i_max_len),
        .i_wr_rdy      (i_wr_rdy),
        .o_wr_act      (o_wr_act),
        .i_wr_size     (i_wr_size),
        .o_wr_stb      (o_wr_stb),
        .o_wr_data     (o_wr_data),
        .o_frame_done  (o_frame_done),
        .o_frame_count (o_frame_count)
    );

    typedef struct {
        int          ch;
        int          len;
        int          gap;
        logic [15:0] fcnt;
    } frame_t;

    frame_t      exp_frames[$];
    logic [7:0]  exp_data[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          stb_cnt = 0;
    int          done_cnt = 0;

    // Reference state, kept as plain integers and bytes.
    logic [7:0]  cnt_m, lfsr_m, walk_m;
    int          rr_m;
    logic [15:0] fcount_m;

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] model_word(int mode, int idx);
        logic [7:0] v;
        case (mode)
            0: v = 8'(idx);
            1: begin v = cnt_m; cnt_m = cnt_m + 8'd1; end
            2: begin v = lfsr_m; lfsr_m = (lfsr_m >> 1) ^ (lfsr_m[0] ? TAPS : 8'h00); end
            default: begin v = walk_m; walk_m = {walk_m[6:0], walk_m[7]}; end
        endcase
        return v;
    endfunction

    function automatic void plan_frames(int n, logic [1:0] rdy, int size, int maxlen, int mode, int gap);
        for (int k = 0; k < n; k++) begin
            int ch;
            int len;
            ch = -1;
            for (int o = 0; o < NCH; o++) begin
                if (ch < 0 && rdy[(rr_m + o) % NCH]) ch = (rr_m + o) % NCH;
            end
            rr_m = (ch + 1) % NCH;
            len = (maxlen != 0 && maxlen < size) ? maxlen : size;
            for (int w = 0; w < len; w++) exp_data.push_back(model_word(mode, w));
            fcount_m = fcount_m + 16'd1;
            exp_frames.push_back('{ch, len, gap, fcount_m});
        end
    endfunction

    task automatic do_reset(input logic [7:0] seed);
        i_enable = 1'b0;
        i_wr_rdy = '0;
        i_seed   = seed;
        rst      = 1'b0;
        @(posedge clk); #1;
        chk("rst_act", o_wr_act, 0);
        chk("rst_stb", o_wr_stb, 0);
        chk("rst_data", o_wr_data, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_fcount", o_frame_count, 0);
        @(posedge clk); #1;
        rst      = 1'b1;
        cnt_m    = seed;
        lfsr_m   = (seed == 8'h00) ? 8'h01 : seed;
        walk_m   = 8'h01;
        rr_m     = 0;
        fcount_m = 16'd0;
        exp_data.delete();
        exp_frames.delete();
    endtask

    task automatic run_frames(input int n, input logic [1:0] rdy, input int size, input int maxlen,
                              input int mode, input int gap, input bit rnd_en, input int stall_after);
        int  target;
        int  base;
        bit  stalled;
        i_wr_rdy  = rdy;
        i_wr_size = 16'(size);
        i_max_len = 16'(maxlen);
        i_mode    = 2'(mode);
        i_gap     = 8'(gap);
        plan_frames(n, rdy, size, maxlen, mode, gap);
        target   = done_cnt + n;
        base     = stb_cnt;
        stalled  = 1'b0;
        i_enable = 1'b1;
        for (int c = 0; c < 3000 && done_cnt < target; c++) begin
            @(posedge clk); #1;
            if (stall_after >= 0 && !stalled && stb_cnt >= base + stall_after) begin
                i_enable = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                i_enable = 1'b1;
                stalled  = 1'b1;
            end else if (rnd_en) begin
                i_enable = ($urandom_range(0, 7) != 0);
            end
        end
        chk("run_done_in_time", done_cnt >= target, 1);
        i_wr_rdy = '0;
        i_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("data_queue_drained", exp_data.size(), 0);
        chk("frame_queue_drained", exp_frames.size(), 0);
    endtask

    // Monitor: enable/reset are sampled at the active edge, outputs half a cycle later.
    initial begin
        frame_t cur;
        bit     in_frame;
        bit     en_e;
        bit     rst_e;
        int     nstb;
        int     idle_en;
        longint cyc;
        longint last_done;
        in_frame  = 1'b0;
        nstb      = 0;
        idle_en   = 0;
        cyc       = 0;
        last_done = -100;
        cur       = '{0, 0, 0, 16'd0};
        forever begin
            @(posedge clk);
            en_e  = i_enable;
            rst_e = rst;
            @(negedge clk);
            cyc++;
            if (!rst_e) begin
                in_frame  = 1'b0;
                last_done = -100;
            end else if (!in_frame && o_wr_act != '0) begin
                if (exp_frames.size() == 0) begin
                    chk("unexpected_act", o_wr_act, 0);
                end else begin
                    cur = exp_frames.pop_front();
                    chk("grant", o_wr_act, 1 << cur.ch);
                    chk("release_gap_ok", (cyc - last_done) >= 2, 1);
                    chk("no_stb_on_grant", o_wr_stb, 0);
                    in_frame = 1'b1;
                    nstb     = 0;
                    idle_en  = 0;
                end
            end else if (in_frame) begin
                if (o_wr_stb) begin
                    chk("stb_enabled", en_e, 1);
                    chk("stb_spacing", idle_en, (nstb == 0) ? 0 : cur.gap);
                    chk("act_hold", o_wr_act, 1 << cur.ch);
                    if (exp_data.size() == 0) chk("unexpected_stb", o_wr_data, 0);
                    else chk("data", o_wr_data, exp_data.pop_front());
                    nstb++;
                    stb_cnt++;
                    idle_en = 0;
                end else if (o_frame_done) begin
                    chk("done_enabled", en_e, 1);
                    chk("act_release", o_wr_act, 0);
                    chk("frame_len", nstb, cur.len);
                    chk("done_latency", idle_en, 0);
                    chk("frame_count", o_frame_count, cur.fcnt);
                    in_frame  = 1'b0;
                    last_done = cyc;
                    done_cnt++;
                end else if (en_e) begin
                    idle_en++;
                end
            end else if (o_wr_stb || o_frame_done) begin
                chk("stray_pulse", {o_wr_stb, o_frame_done}, 0);
            end
        end
    end

    initial begin
        int base;
        i_mode    = 2'd0;
        i_gap     = 8'd0;
        i_max_len = 16'd0;
        i_wr_size = 16'd0;
        i_seed    = 8'h00;
        i_enable  = 1'b0;
        i_wr_rdy  = '0;
        rst       = 1'b0;

        do_reset(8'h00);
        run_frames(1, 2'b01, 4, 0, 0, 0, 1'b0, -1);
        do_reset(8'h00);
        run_frames(3, 2'b11, 2, 0, 0, 0, 1'b0, -1);

        do_reset(8'hFE);
        run_frames(1, 2'b01, 8, 3, 1, 0, 1'b0, -1);
        run_frames(1, 2'b01, 8, 3, 1, 0, 1'b0, -1);

        do_reset(8'h00);
        run_frames(1, 2'b01, 4, 0, 2, 2, 1'b0, -1);
        run_frames(1, 2'b10, 0, 0, 0, 0, 1'b0, -1);
        run_frames(1, 2'b01, 6, 0, 3, 0, 1'b0, 2);
        run_frames(1, 2'b10, 7, 0, 1, 1, 1'b0, 3);

        do_reset(8'($urandom));
        for (int r = 0; r < 25; r++) begin
            run_frames($urandom_range(1, 3), 2'($urandom_range(1, 3)), $urandom_range(0, 6),
                       $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, -1);
        end

        // Reset in the middle of a frame, then confirm a clean restart.
        i_wr_rdy  = 2'b01;
        i_wr_size = 16'd8;
        i_max_len = 16'd0;
        i_mode    = 2'd0;
        i_gap     = 8'd0;
        plan_frames(1, 2'b01, 8, 0, 0, 0);
        base     = stb_cnt;
        i_enable = 1'b1;
        for (int c = 0; c < 200 && stb_cnt < base + 3; c++) begin
            @(posedge clk); #1;
        end
        chk("midframe_strobes_seen", stb_cnt >= base + 3, 1);
        do_reset(8'h00);
        run_frames(1, 2'b01, 2, 0, 0, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
